// File: rtl/risc16ba_mmio_pkg.sv
// Shared constants and types for the risc16ba I/O window.
// Offsets are byte offsets inside the 16-byte window.
package risc16ba_mmio_pkg;

  localparam logic [3:0] OFF_LED        = 4'h0;
  localparam logic [3:0] OFF_LED2       = 4'h2;
  localparam logic [3:0] OFF_CYC_LO     = 4'h4;
  localparam logic [3:0] OFF_CYC_HI     = 4'h6;
  localparam logic [3:0] OFF_TMR_RELOAD = 4'h8;
  localparam logic [3:0] OFF_TMR_CTRL   = 4'hA;
  localparam logic [3:0] OFF_TMR_COUNT  = 4'hC;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_EXP  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/risc16ba_timer.sv
// Countdown timer: reload/ctrl registers, prescaler,
// count, run state and sticky expiry flag.
module risc16ba_timer
  import risc16ba_mmio_pkg::*;
#(
  parameter int unsigned PRESCALE = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload_we0_i,
  input  logic        reload_we1_i,
  input  logic        ctrl_we0_i,
  input  logic        ctrl_we1_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] reload_o,
  output logic [15:0] ctrl_o,
  output logic [15:0] count_o,
  output logic        irq_o
);

  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  tmr_state_e  state_q, state_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [15:0] presc_q, presc_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        ie_q, ie_d;
  logic        exp_q, exp_d;
  logic        tick;

  assign tick = (state_q == RUN) && (presc_q == PS_MAX);

  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    count_d  = count_q;
    presc_d  = presc_q;
    en_d     = en_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    exp_d    = exp_q;

    if (reload_we0_i) reload_d[15:8] = wdata_i[15:8];
    if (reload_we1_i) reload_d[7:0]  = wdata_i[7:0];

    if (ctrl_we1_i) begin
      en_d   = wdata_i[CTRL_EN];
      auto_d = wdata_i[CTRL_AUTO];
      ie_d   = wdata_i[CTRL_IE];
    end
    if (ctrl_we0_i && wdata_i[CTRL_EXP]) exp_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctrl_we1_i && wdata_i[CTRL_EN]) begin
          state_d = RUN;
          count_d = reload_d;
          presc_d = '0;
        end
      end
      RUN: begin
        if (ctrl_we1_i && !wdata_i[CTRL_EN]) begin
          state_d = IDLE;
        end else begin
          presc_d = tick ? '0 : presc_q + 16'd1;
          if (tick) begin
            if (count_q != '0) begin
              count_d = count_q - 16'd1;
            end else begin
              // expiry set overrides a same-cycle clear
              exp_d = 1'b1;
              if (auto_q) begin
                count_d = reload_d;
              end else begin
                en_d    = 1'b0;
                state_d = IDLE;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      reload_q <= '0;
      count_q  <= '0;
      presc_q  <= '0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      exp_q    <= exp_d;
    end
  end

  always_comb begin
    ctrl_o            = '0;
    ctrl_o[CTRL_EN]   = en_q;
    ctrl_o[CTRL_AUTO] = auto_q;
    ctrl_o[CTRL_IE]   = ie_q;
    ctrl_o[CTRL_EXP]  = exp_q;
  end

  assign reload_o = reload_q;
  assign count_o  = count_q;
  assign irq_o    = exp_q & ie_q;

endmodule

// File: rtl/risc16ba_mmio.sv
// Data-bus decoder for the risc16ba core: I/O window with LEDs,
// cycle counter and timer; everything else passes to memory.
module risc16ba_mmio
  import risc16ba_mmio_pkg::*;
#(
  parameter int unsigned PRESCALE = 25,
  parameter logic [15:0] IO_BASE  = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] daddr,
  input  logic [15:0] ddout,
  input  logic        doe,
  input  logic        dwe0,
  input  logic        dwe1,
  output logic [15:0] ddin,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_oe,
  output logic        mem_we0,
  output logic        mem_we1,
  input  logic [15:0] mem_rdata,
  output logic [23:0] led,
  output logic        irq
);

  logic        io_hit;
  logic [3:0]  off;
  logic        unused_addr0;
  logic        io_we0, io_we1, io_rd;
  logic [23:0] led_q, led_d;
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] cyc_hi_q, cyc_hi_d;
  logic [15:0] rd_data;
  logic [15:0] tmr_reload, tmr_ctrl, tmr_count;

  assign io_hit       = (daddr[15:4] == IO_BASE[15:4]);
  assign off          = {daddr[3:1], 1'b0};
  assign unused_addr0 = daddr[0];

  assign io_we0 = io_hit & dwe0;
  assign io_we1 = io_hit & dwe1;
  assign io_rd  = io_hit & doe;

  assign mem_addr  = daddr;
  assign mem_wdata = ddout;
  assign mem_oe    = doe  & ~io_hit;
  assign mem_we0   = dwe0 & ~io_hit;
  assign mem_we1   = dwe1 & ~io_hit;

  always_comb begin
    led_d    = led_q;
    cyc_d    = cyc_q + 32'd1;
    cyc_hi_d = cyc_hi_q;
    if (io_we0 && off == OFF_LED)  led_d[15:8]  = ddout[15:8];
    if (io_we1 && off == OFF_LED)  led_d[7:0]   = ddout[7:0];
    if (io_we1 && off == OFF_LED2) led_d[23:16] = ddout[7:0];
    // high half frozen by the low-half read for a coherent pair
    if (io_rd && off == OFF_CYC_LO) cyc_hi_d = cyc_q[31:16];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q    <= '0;
      cyc_q    <= '0;
      cyc_hi_q <= '0;
    end else begin
      led_q    <= led_d;
      cyc_q    <= cyc_d;
      cyc_hi_q <= cyc_hi_d;
    end
  end

  risc16ba_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .reload_we0_i(io_we0 && off == OFF_TMR_RELOAD),
    .reload_we1_i(io_we1 && off == OFF_TMR_RELOAD),
    .ctrl_we0_i  (io_we0 && off == OFF_TMR_CTRL),
    .ctrl_we1_i  (io_we1 && off == OFF_TMR_CTRL),
    .wdata_i     (ddout),
    .reload_o    (tmr_reload),
    .ctrl_o      (tmr_ctrl),
    .count_o     (tmr_count),
    .irq_o       (irq)
  );

  always_comb begin
    rd_data = '0;
    if (io_rd) begin
      unique case (1'b1)
        (off == OFF_LED):        rd_data = led_q[15:0];
        (off == OFF_LED2):       rd_data = {8'h00, led_q[23:16]};
        (off == OFF_CYC_LO):     rd_data = cyc_q[15:0];
        (off == OFF_CYC_HI):     rd_data = cyc_hi_q;
        (off == OFF_TMR_RELOAD): rd_data = tmr_reload;
        (off == OFF_TMR_CTRL):   rd_data = tmr_ctrl;
        (off == OFF_TMR_COUNT):  rd_data = tmr_count;
        default:                 rd_data = '0;
      endcase
    end
  end

  assign ddin = io_hit ? rd_data : mem_rdata;
  assign led  = led_q;

endmodule
